// File: rtl/agc_pkg.sv
// Shared types and default widths for the AGC flag accumulator.
package agc_pkg;

    // Default sizing for one channel instance.
    localparam int DEF_NSAMP = 8;
    localparam int DEF_LEN_W = 24;
    localparam int DEF_CNT_W = 32;
    localparam int DEF_SQ_W  = 40;

    // Largest magnitude a lane can report; its square bounds the per-lane term.
    localparam int ABS_MAX = 15;

    // Window control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } agc_state_e;

    // Clocks between the last accepted sample and the accumulators holding it
    // (S1 register, S2 register); the results are latched on the edge after.
    localparam int DRAIN_CYC = 2;

    // Bits needed for the sum of NSAMP squared magnitudes in one clock.
    function automatic int sq_lane_sum_w(input int nsamp);
        return $clog2(ABS_MAX * ABS_MAX + 1) + $clog2(nsamp);
    endfunction

endpackage

// File: rtl/agc_flag_accumulator_if.sv
// Sample-lane inputs, window control and result bus for one AGC channel.
interface agc_flag_accumulator_if
    import agc_pkg::*;
#(
    parameter int NSAMP = DEF_NSAMP,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int SQ_W  = DEF_SQ_W
);
    // Lane data from the saturators.
    logic               valid_i;
    logic [NSAMP-1:0]   gt_i;
    logic [NSAMP-1:0]   lt_i;
    logic [4*NSAMP-1:0] abs_i;

    // Window control from the register bank.
    logic [LEN_W-1:0]   len_i;
    logic               start_i;
    logic               ack_i;

    // Results back to the register bank.
    logic               busy_o;
    logic               done_o;
    logic [CNT_W-1:0]   gt_count_o;
    logic [CNT_W-1:0]   lt_count_o;
    logic [CNT_W:0]     sum_o;
    logic [CNT_W:0]     diff_o;
    logic [SQ_W-1:0]    sqsum_o;

    // Producer side: saturators plus register bank.
    modport master (
        output valid_i, gt_i, lt_i, abs_i, len_i, start_i, ack_i,
        input  busy_o, done_o, gt_count_o, lt_count_o, sum_o, diff_o, sqsum_o
    );

    // Accumulator side.
    modport slave (
        input  valid_i, gt_i, lt_i, abs_i, len_i, start_i, ack_i,
        output busy_o, done_o, gt_count_o, lt_count_o, sum_o, diff_o, sqsum_o
    );

endinterface

// File: rtl/agc_lane_reduce.sv
// Two-stage reduction of one clock of lane data: S1 registers the raw lanes,
// S2 registers the GT/LT popcounts and the sum of squared magnitudes.
module agc_lane_reduce
    import agc_pkg::*;
#(
    parameter int NSAMP = DEF_NSAMP,
    parameter int POP_W = $clog2(NSAMP + 1),
    parameter int SQL_W = sq_lane_sum_w(NSAMP)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               i_valid,
    input  logic [NSAMP-1:0]   i_gt,
    input  logic [NSAMP-1:0]   i_lt,
    input  logic [4*NSAMP-1:0] i_abs,
    output logic               o_valid,
    output logic [POP_W-1:0]   o_gt_pop,
    output logic [POP_W-1:0]   o_lt_pop,
    output logic [SQL_W-1:0]   o_sqsum
);

    logic               r_s1_valid;
    logic [NSAMP-1:0]   r_s1_gt;
    logic [NSAMP-1:0]   r_s1_lt;
    logic [4*NSAMP-1:0] r_s1_abs;

    logic               r_s2_valid;
    logic [POP_W-1:0]   r_s2_gt_pop;
    logic [POP_W-1:0]   r_s2_lt_pop;
    logic [SQL_W-1:0]   r_s2_sqsum;

    logic [POP_W-1:0]   w_gt_pop;
    logic [POP_W-1:0]   w_lt_pop;
    logic [SQL_W-1:0]   w_sqsum;
    logic [SQL_W-1:0]   w_lane_abs;

    // S1: capture the raw lane data for this clock.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block ordering. The data registers are
    // reset as well so a reset mid-window leaves no stale lane data behind.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_gt    <= '0;
            r_s1_lt    <= '0;
            r_s1_abs   <= '0;
        end else begin
            r_s1_valid <= i_valid;
            r_s1_gt    <= i_gt;
            r_s1_lt    <= i_lt;
            r_s1_abs   <= i_abs;
        end
    end

    // Count flags and sum the squared magnitudes across all lanes.
    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_gt_pop   = '0;
        w_lt_pop   = '0;
        w_sqsum    = '0;
        w_lane_abs = '0;
        for (int n = 0; n < NSAMP; n++) begin
            w_gt_pop   = w_gt_pop + POP_W'(r_s1_gt[n]);
            w_lt_pop   = w_lt_pop + POP_W'(r_s1_lt[n]);
            w_lane_abs = SQL_W'(r_s1_abs[4*n +: 4]);
            w_sqsum    = w_sqsum + w_lane_abs * w_lane_abs;
        end
    end

    // S2: register the per-clock reduction alongside its valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid  <= 1'b0;
            r_s2_gt_pop <= '0;
            r_s2_lt_pop <= '0;
            r_s2_sqsum  <= '0;
        end else begin
            r_s2_valid  <= r_s1_valid;
            r_s2_gt_pop <= w_gt_pop;
            r_s2_lt_pop <= w_lt_pop;
            r_s2_sqsum  <= w_sqsum;
        end
    end

    assign o_valid  = r_s2_valid;
    assign o_gt_pop = r_s2_gt_pop;
    assign o_lt_pop = r_s2_lt_pop;
    assign o_sqsum  = r_s2_sqsum;

endmodule

// File: rtl/agc_flag_accumulator.sv
// Window-based GT/LT/square-sum accumulator for one AGC channel. A start
// opens a window of len valid clocks; after the pipeline drains, the totals
// and their sum/difference are latched and held until acknowledged.
module agc_flag_accumulator
    import agc_pkg::*;
#(
    parameter int NSAMP = DEF_NSAMP,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int SQ_W  = DEF_SQ_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    agc_flag_accumulator_if.slave bus
);

    localparam int POP_W = $clog2(NSAMP + 1);
    localparam int SQL_W = sq_lane_sum_w(NSAMP);

    agc_state_e       r_state;
    logic [LEN_W-1:0] r_remaining;
    logic [1:0]       r_drain_cnt;

    logic [CNT_W-1:0] r_gt_acc;
    logic [CNT_W-1:0] r_lt_acc;
    logic [SQ_W-1:0]  r_sq_acc;

    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_gt_count;
    logic [CNT_W-1:0] r_lt_count;
    logic [CNT_W:0]   r_sum;
    logic [CNT_W:0]   r_diff;
    logic [SQ_W-1:0]  r_sqsum;

    logic             w_start_ok;
    logic             w_accept;
    logic             w_red_valid;
    logic [POP_W-1:0] w_gt_pop;
    logic [POP_W-1:0] w_lt_pop;
    logic [SQL_W-1:0] w_sqsum;

    // Lane data only enters the pipeline on valid clocks inside a window.
    assign w_start_ok = (r_state == ST_IDLE) && bus.start_i;
    assign w_accept   = (r_state == ST_RUN) && bus.valid_i;

    agc_lane_reduce #(
        .NSAMP (NSAMP),
        .POP_W (POP_W),
        .SQL_W (SQL_W)
    ) u_lane_reduce (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_valid  (w_accept),
        .i_gt     (bus.gt_i),
        .i_lt     (bus.lt_i),
        .i_abs    (bus.abs_i),
        .o_valid  (w_red_valid),
        .o_gt_pop (w_gt_pop),
        .o_lt_pop (w_lt_pop),
        .o_sqsum  (w_sqsum)
    );

    // Window control: count accepted clocks, drain the pipeline, then latch
    // and hold results until acknowledged. Start is only honoured in IDLE,
    // and ack is only honoured in HOLD, so a combined start+ack drops start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_drain_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_gt_count  <= '0;
            r_lt_count  <= '0;
            r_sum       <= '0;
            r_diff      <= '0;
            r_sqsum     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        // A zero-length request still collects one valid clock.
                        r_remaining <= (bus.len_i == '0) ? LEN_W'(1) : bus.len_i;
                        r_busy      <= 1'b1;
                        r_state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.valid_i) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_drain_cnt <= 2'(DRAIN_CYC);
                            r_state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == 2'd0) begin
                        r_gt_count <= r_gt_acc;
                        r_lt_count <= r_lt_acc;
                        r_sum      <= {1'b0, r_gt_acc} + {1'b0, r_lt_acc};
                        r_diff     <= {1'b0, r_gt_acc} - {1'b0, r_lt_acc};
                        r_sqsum    <= r_sq_acc;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= ST_HOLD;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 2'd1;
                    end
                end
                ST_HOLD: begin
                    if (bus.ack_i) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // S3: clear on an accepted start, otherwise add each reduced clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_gt_acc <= '0;
            r_lt_acc <= '0;
            r_sq_acc <= '0;
        end else if (w_start_ok) begin
            r_gt_acc <= '0;
            r_lt_acc <= '0;
            r_sq_acc <= '0;
        end else if (w_red_valid) begin
            r_gt_acc <= r_gt_acc + CNT_W'(w_gt_pop);
            r_lt_acc <= r_lt_acc + CNT_W'(w_lt_pop);
            r_sq_acc <= r_sq_acc + SQ_W'(w_sqsum);
        end
    end

    assign bus.busy_o     = r_busy;
    assign bus.done_o     = r_done;
    assign bus.gt_count_o = r_gt_count;
    assign bus.lt_count_o = r_lt_count;
    assign bus.sum_o      = r_sum;
    assign bus.diff_o     = r_diff;
    assign bus.sqsum_o    = r_sqsum;

endmodule

// File: tb/tb_agc_flag_accumulator.sv
// Directed bench for agc_flag_accumulator with a window-level reference model.
module tb_agc_flag_accumulator;
    import agc_pkg::*;

    localparam int NSAMP = DEF_NSAMP;
    localparam int LEN_W = DEF_LEN_W;
    localparam int CNT_W = DEF_CNT_W;
    localparam int SQ_W  = DEF_SQ_W;
    localparam int DW    = CNT_W + 1;

    logic clk    = 1'b0;
    logic rst_ni = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    agc_flag_accumulator_if #(
        .NSAMP (NSAMP), .LEN_W (LEN_W), .CNT_W (CNT_W), .SQ_W (SQ_W)
    ) bus ();

    agc_flag_accumulator #(
        .NSAMP (NSAMP), .LEN_W (LEN_W), .CNT_W (CNT_W), .SQ_W (SQ_W)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- window-level reference model ----------------
    // Totals are summed straight from the inputs on each accepted clock; the
    // results appear three edges after the last accepted sample.
    int               m_phase    = 0;   // 0 idle, 1 collecting, 2 waiting, 3 holding
    longint           m_rem      = 0;
    longint           m_gt       = 0;
    longint           m_lt       = 0;
    longint           m_sq       = 0;
    longint           m_cyc      = 0;
    longint           m_done_cyc = 0;
    logic             e_busy     = 1'b0;
    logic             e_done     = 1'b0;
    logic [CNT_W-1:0] e_gt       = '0;
    logic [CNT_W-1:0] e_lt       = '0;
    logic [DW-1:0]    e_sum      = '0;
    logic [DW-1:0]    e_diff     = '0;
    logic [SQ_W-1:0]  e_sq       = '0;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_phase = 0; m_rem = 0; m_gt = 0; m_lt = 0; m_sq = 0;
            e_busy = 1'b0; e_done = 1'b0;
            e_gt = '0; e_lt = '0; e_sum = '0; e_diff = '0; e_sq = '0;
        end else begin
            m_cyc++;
            case (m_phase)
                0: if (bus.start_i) begin
                    m_rem = (bus.len_i == '0) ? 64'd1 : longint'(bus.len_i);
                    m_gt = 0; m_lt = 0; m_sq = 0;
                    e_busy = 1'b1;
                    m_phase = 1;
                end
                1: if (bus.valid_i) begin
                    m_gt += $countones(bus.gt_i);
                    m_lt += $countones(bus.lt_i);
                    for (int n = 0; n < NSAMP; n++) begin
                        longint a;
                        a = longint'(bus.abs_i[4*n +: 4]);
                        m_sq += a * a;
                    end
                    m_rem--;
                    if (m_rem == 0) begin
                        m_done_cyc = m_cyc + 3;
                        m_phase = 2;
                    end
                end
                2: if (m_cyc == m_done_cyc) begin
                    e_gt   = CNT_W'(m_gt);
                    e_lt   = CNT_W'(m_lt);
                    e_sum  = DW'(m_gt + m_lt);
                    e_diff = DW'(m_gt - m_lt);
                    e_sq   = SQ_W'(m_sq);
                    e_done = 1'b1;
                    e_busy = 1'b0;
                    m_phase = 3;
                end
                default: if (bus.ack_i) begin
                    e_done = 1'b0;
                    m_phase = 0;
                end
            endcase
        end
    end

    // Every cycle out of reset, the DUT must match the model.
    always @(negedge clk) begin
        if (rst_ni) begin
            check("cyc_busy",  bus.busy_o,     e_busy);
            check("cyc_done",  bus.done_o,     e_done);
            check("cyc_gt",    bus.gt_count_o, e_gt);
            check("cyc_lt",    bus.lt_count_o, e_lt);
            check("cyc_sum",   bus.sum_o,      e_sum);
            check("cyc_diff",  bus.diff_o,     e_diff);
            check("cyc_sqsum", bus.sqsum_o,    e_sq);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.valid_i = 1'b0;
        bus.gt_i    = '0;
        bus.lt_i    = '0;
        bus.abs_i   = '0;
        bus.len_i   = '0;
        bus.start_i = 1'b0;
        bus.ack_i   = 1'b0;
    endtask

    task automatic start_win(input int len);
        bus.len_i   = LEN_W'(len);
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int k;
        k = 0;
        while (bus.done_o !== 1'b1 && k < max_cyc) begin
            step();
            k++;
        end
        check(name, bus.done_o, 1'b1);
    endtask

    task automatic ack_win(input string name);
        bus.ack_i = 1'b1;
        step();
        bus.ack_i = 1'b0;
        check({name, "_done_low"}, bus.done_o, 1'b0);
        check({name, "_busy_low"}, bus.busy_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] pat;
        idle_in();
        #1 rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  bus.busy_o,     1'b0);
        check("rst_done",  bus.done_o,     1'b0);
        check("rst_gt",    bus.gt_count_o, 0);
        check("rst_sqsum", bus.sqsum_o,    0);
        rst_ni = 1'b1;
        step();

        // T1: len=4, all GT flags, done three clocks after the 4th sample.
        start_win(4);
        check("t1_busy_rise", bus.busy_o, 1'b1);
        bus.valid_i = 1'b1; bus.gt_i = 8'hFF;
        repeat (4) step();
        bus.valid_i = 1'b0; bus.gt_i = '0;
        step(); step();
        check("t1_done_early", bus.done_o, 1'b0);
        step();
        check("t1_done_t3", bus.done_o, 1'b1);
        check("t1_busy_fall", bus.busy_o, 1'b0);
        check("t1_gt",   bus.gt_count_o, 32);
        check("t1_lt",   bus.lt_count_o, 0);
        check("t1_sum",  bus.sum_o,  32);
        check("t1_diff", bus.diff_o, 32);
        check("t1_model_gt", e_gt, 32);
        ack_win("t1_ack");

        // T2: len=2, all magnitudes 15.
        start_win(2);
        bus.valid_i = 1'b1; bus.abs_i = 32'hFFFF_FFFF;
        repeat (2) step();
        bus.valid_i = 1'b0; bus.abs_i = '0;
        wait_done("t2_done", 8);
        check("t2_sqsum", bus.sqsum_o, 3600);
        check("t2_sum",   bus.sum_o,   0);
        check("t2_diff",  bus.diff_o,  0);
        ack_win("t2_ack");

        // T3: len=3 with gaps; stray ack during RUN is ignored.
        start_win(3);
        bus.lt_i = 8'h01;
        pat = 6'b100101;   // bit i = valid on clock i: 1,0,1,0,0,1
        for (int i = 0; i < 6; i++) begin
            bus.valid_i = pat[i];
            bus.ack_i   = (i == 0);
            step();
            if (i == 4) begin
                check("t3_not_short_busy", bus.busy_o, 1'b1);
                check("t3_not_short_done", bus.done_o, 1'b0);
            end
        end
        bus.valid_i = 1'b0; bus.lt_i = '0; bus.ack_i = 1'b0;
        wait_done("t3_done", 8);
        check("t3_lt",   bus.lt_count_o, 3);
        check("t3_gt",   bus.gt_count_o, 0);
        check("t3_diff", bus.diff_o, 33'h1_FFFF_FFFD);
        ack_win("t3_ack");

        // T4: len=0 acts as len=1; minimum window done at start+4.
        start_win(0);
        bus.valid_i = 1'b1; bus.gt_i = 8'h03;
        step();
        bus.valid_i = 1'b0; bus.gt_i = '0;
        step(); step();
        check("t4_done_early", bus.done_o, 1'b0);
        step();
        check("t4_done_min", bus.done_o, 1'b1);
        check("t4_gt", bus.gt_count_o, 2);
        ack_win("t4_ack");

        // T5: start ignored in RUN, in HOLD, and when paired with ack.
        start_win(2);
        bus.valid_i = 1'b1; bus.gt_i = 8'h01;
        step();
        bus.start_i = 1'b1; bus.len_i = LEN_W'(5);
        step();
        bus.start_i = 1'b0; bus.valid_i = 1'b0; bus.gt_i = '0;
        wait_done("t5_done", 8);
        check("t5_gt", bus.gt_count_o, 2);
        bus.start_i = 1'b1; bus.len_i = LEN_W'(7);
        step();
        bus.start_i = 1'b0;
        step();
        check("t5_hold_done", bus.done_o, 1'b1);
        check("t5_hold_gt",   bus.gt_count_o, 2);
        bus.start_i = 1'b1; bus.ack_i = 1'b1;
        step();
        bus.start_i = 1'b0; bus.ack_i = 1'b0;
        check("t5_ackwin_done", bus.done_o, 1'b0);
        step();
        check("t5_start_dropped", bus.busy_o, 1'b0);
        check("t5_keep_gt", bus.gt_count_o, 2);

        // T6: reset mid-RUN, then a clean window.
        start_win(10);
        bus.valid_i = 1'b1; bus.gt_i = 8'hFF; bus.lt_i = 8'hFF; bus.abs_i = 32'h1111_1111;
        repeat (3) step();
        #2 rst_ni = 1'b0;
        #1;
        check("t6_rst_busy",  bus.busy_o,     1'b0);
        check("t6_rst_done",  bus.done_o,     1'b0);
        check("t6_rst_gt",    bus.gt_count_o, 0);
        check("t6_rst_lt",    bus.lt_count_o, 0);
        check("t6_rst_sum",   bus.sum_o,      0);
        check("t6_rst_diff",  bus.diff_o,     0);
        check("t6_rst_sqsum", bus.sqsum_o,    0);
        idle_in();
        rst_ni = 1'b1;
        step();
        start_win(1);
        bus.valid_i = 1'b1; bus.gt_i = 8'h0F; bus.lt_i = 8'hF0; bus.abs_i = 32'h0000_0003;
        step();
        idle_in();
        wait_done("t6_done", 8);
        check("t6_gt",    bus.gt_count_o, 4);
        check("t6_lt",    bus.lt_count_o, 4);
        check("t6_sum",   bus.sum_o,      8);
        check("t6_diff",  bus.diff_o,     0);
        check("t6_sqsum", bus.sqsum_o,    9);
        ack_win("t6_ack");

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/agc_flag_accumulator.md
# agc_flag_accumulator

Consumer end of the per-sample saturate/scale output. Takes the symmetric greater-than and less-than flags and the 4-bit magnitude produced for each sample lane. Over a software-started window, it accumulates GT count, LT count and sum of squared magnitudes. It then presents GT+LT (gain error), GT−LT (DC/symmetry error) and the square-sum (RMS) to the AGC control register interface, using a done/ack handshake. It sits between the per-lane saturators and the AGC register bank, one instance per channel.

## Interface
Parameters:
- NSAMP, 8, sample lanes per clock.
- LEN_W, 24, width of window-length input (clocks).
- CNT_W, 32, width of GT/LT/sum counters; must be ≥ LEN_W+$clog2(NSAMP+1).
- SQ_W, 40, width of square-sum accumulator; must be ≥ LEN_W+$clog2(NSAMP)+8.

Ports:
- clk_i  in  1  sample clock.
- rst_ni  in  1  reset. Asynchronous assert, active-low.
- valid_i  in  1  lane data below is a valid sample clock.
- gt_i  in  NSAMP  per-lane greater-than flag.
- lt_i  in  NSAMP  per-lane less-than flag.
- abs_i  in  4*NSAMP  per-lane magnitude, lane n at [4n +: 4], range 0–15.
- len_i  in  LEN_W  window length in valid clocks; sampled on accepted start.
- start_i  in  1  single-cycle request to begin a window.
- ack_i  in  1  results consumed; releases HOLD.
- busy_o  out  1  high in RUN or DRAIN.
- done_o  out  1  results valid (HOLD).
- gt_count_o  out  CNT_W  total GT flags in window.
- lt_count_o  out  CNT_W  total LT flags in window.
- sum_o  out  CNT_W+1  gt_count+lt_count, unsigned.
- diff_o  out  CNT_W+1  gt_count−lt_count, two's complement.
- sqsum_o  out  SQ_W  Σ abs².

## Operation
- States: IDLE, RUN, DRAIN, HOLD. Reset to IDLE. All outputs and accumulators reset to 0.
- IDLE:
  - On start_i: latch len_i into the remaining counter, clear all accumulators, go to RUN.
  - len_i=0 is treated as 1.
- RUN:
  - Each clock with valid_i=1, the lane data enters the pipeline and the remaining counter decrements.
  - When the accepting clock has remaining=1, go to DRAIN.
  - Clocks with valid_i=0 contribute nothing and do not count.
- DRAIN: wait until the last accepted sample has reached the accumulators, then latch all outputs and go to HOLD.
- HOLD:
  - done_o=1; outputs are held stable.
  - On ack_i: go to IDLE, with done_o low next cycle. Outputs keep their last values.
- start_i outside IDLE is ignored and not queued. start_i and ack_i together in HOLD: ack wins, start is dropped.
- ack_i outside HOLD is ignored.
- GT and LT are counted independently per lane. A lane with both set, which is illegal upstream, adds 1 to each.
- Per clock: popcount(gt_i) and popcount(lt_i) are each 0..NSAMP. Σ abs² per clock is ≤ 225·NSAMP.
- Accumulators cannot overflow within the parameter constraints. No saturation logic.
- rst_ni low in any state: immediate return to IDLE, in-flight window discarded, outputs zeroed.

## Timing
- Pipeline, 3 stages:
  - S1: register valid/gt/lt/abs.
  - S2: popcounts and per-lane squares summed (registered).
  - S3: accumulate.
- Last valid sample accepted at edge t → accumulators final at t+2 → outputs latched and done_o=1 from edge t+3.
- busy_o rises the edge after start_i is accepted. busy_o falls on the edge done_o rises.
- Minimum window (len=1, valid_i held high): start at edge s, done_o at s+4.
- Back-to-back windows: the next start_i is accepted no earlier than the first IDLE cycle after ack_i.

## Structure
- Package agc_pkg holds:
  - state enum (IDLE/RUN/DRAIN/HOLD);
  - default widths NSAMP/LEN_W/CNT_W/SQ_W;
  - localparam ABS_MAX=15.
- Sub-module agc_lane_reduce: S1/S2 registered reduction. Outputs gt popcount, lt popcount and Σ abs², with a 2-cycle valid pipe.
- The FSM, remaining counter and accumulators live in the top module.

## Test plan
- len=4, valid_i=1, gt_i=8'hFF, lt_i=0 → gt_count=32, lt_count=0, sum=32, diff=+32, done_o 3 clocks after the 4th accepted sample.
- len=2, all abs=15, gt=lt=0 → sqsum=3600, sum=0, diff=0.
- len=3, valid_i pattern 1,0,1,0,0,1 with lt_i=8'h01 each valid clock → lt_count=3, diff=−3. Invalid clocks do not shorten the window.
- len=0 with one valid clock of gt_i=8'h03 → behaves as len=1: gt_count=2.
- start_i during RUN and during HOLD (with and without simultaneous ack_i) → ignored. Results unchanged until ack_i, then IDLE.
- rst_ni pulsed low mid-RUN → busy_o=0, done_o=0, all outputs 0 immediately. A fresh start after reset yields correct counts with no carry-over.
